// File: rtl/calc_exec_port.sv
// Single-port command executor: queues held commands in a small FIFO and runs
// add/sub/shl/shr with fixed per-command latency, returning a one-cycle response.
module calc_exec_port #(
    parameter int ADD_LAT    = 3,
    parameter int SHIFT_LAT  = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  hold_prio_req,
    input  logic [0:31] hold_data1,
    input  logic [0:31] hold_data2,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        busy,
    output logic        drop_err
);

    localparam int MAX_LAT = (ADD_LAT > SHIFT_LAT) ? ADD_LAT : SHIFT_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] d1;
        logic [31:0] d2;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    cmd_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [FCNT_W-1:0]  fifo_count_reg;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    cmd_t               cur_reg;
    logic [1:0]         resp_reg;
    logic [1:0]         resp_next;
    logic [31:0]        data_reg;
    logic [31:0]        data_next;
    logic               drop_reg;

    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    cmd_t               head;
    logic [1:0]         exec_resp;
    logic [31:0]        exec_data;
    logic [32:0]        sum;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Counter preload: the EXEC cycle where cnt reaches 0 is the last one.
    function automatic logic [CNT_W-1:0] lat_preload(input logic [3:0] cmd);
        case (cmd)
            4'd1, 4'd2: return CNT_W'(ADD_LAT - 1);
            4'd5, 4'd6: return CNT_W'(SHIFT_LAT - 1);
            default:    return '0;
        endcase
    endfunction

    assign push_req   = (hold_prio_req != 4'd0);
    assign fifo_empty = (fifo_count_reg == '0);
    assign fifo_full  = (fifo_count_reg == FCNT_W'(FIFO_DEPTH));
    assign push_ok    = push_req && (!fifo_full || pop);
    assign head       = fifo_mem[rd_ptr_reg];

    always_ff @(posedge c_clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= {hold_prio_req, hold_data1, hold_data2};
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            fifo_count_reg <= '0;
            drop_reg       <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push_ok && !pop) begin
                fifo_count_reg <= fifo_count_reg + 1'b1;
            end else if (pop && !push_ok) begin
                fifo_count_reg <= fifo_count_reg - 1'b1;
            end
            if (push_req && !push_ok) begin
                drop_reg <= 1'b1;
            end
        end
    end

    assign sum = {1'b0, cur_reg.d1} + {1'b0, cur_reg.d2};

    always_comb begin
        exec_resp = RESP_ERR;
        exec_data = '0;
        case (cur_reg.cmd)
            4'd1: begin
                if (!sum[32]) begin
                    exec_resp = RESP_OK;
                    exec_data = sum[31:0];
                end
            end
            4'd2: begin
                if (cur_reg.d1 >= cur_reg.d2) begin
                    exec_resp = RESP_OK;
                    exec_data = cur_reg.d1 - cur_reg.d2;
                end
            end
            4'd5: begin
                exec_resp = RESP_OK;
                exec_data = cur_reg.d1 << cur_reg.d2[4:0];
            end
            4'd6: begin
                exec_resp = RESP_OK;
                exec_data = cur_reg.d1 >> cur_reg.d2[4:0];
            end
            default: begin
                exec_resp = RESP_ERR;
                exec_data = '0;
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        resp_next  = RESP_NONE;
        data_next  = '0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cnt_next   = lat_preload(head.cmd);
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    resp_next  = exec_resp;
                    data_next  = exec_data;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cnt_next   = lat_preload(head.cmd);
                    state_next = EXEC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cur_reg   <= '0;
            resp_reg  <= RESP_NONE;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            resp_reg  <= resp_next;
            data_reg  <= data_next;
            if (pop) begin
                cur_reg <= head;
            end
        end
    end

    assign out_resp = resp_reg;
    assign out_data = data_reg;
    assign busy     = (state_reg != IDLE) || !fifo_empty;
    assign drop_err = drop_reg;

endmodule

// File: tb/tb_calc_exec_port.sv
// Randomized and directed bench for calc_exec_port against a timeline model of
// queueing, per-command latency and result arithmetic.
module tb_calc_exec_port;

    localparam int ADD_LAT    = 3;
    localparam int SHIFT_LAT  = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int NLOG       = 4096;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:3]  hold_prio_req = '0;
    logic [0:31] hold_data1 = '0;
    logic [0:31] hold_data2 = '0;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        busy;
    logic        drop_err;

    always #5 c_clk = ~c_clk;

    calc_exec_port #(
        .ADD_LAT   (ADD_LAT),
        .SHIFT_LAT (SHIFT_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .hold_prio_req(hold_prio_req),
        .hold_data1   (hold_data1),
        .hold_data2   (hold_data2),
        .out_resp     (out_resp),
        .out_data     (out_data),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Observed outputs in the cycle following each logged edge.
    logic [1:0]  obs_resp [NLOG];
    logic [31:0] obs_data [NLOG];
    logic        obs_busy [NLOG];
    logic        obs_drop [NLOG];

    // Model expectations for the same cycles.
    logic [1:0]  exp_resp [NLOG];
    logic [31:0] exp_data [NLOG];
    logic        exp_busy [NLOG];
    logic        exp_drop [NLOG];

    int   pend_pop[$];
    int   last_r = -1;
    logic m_drop = 1'b0;

    function automatic int lat_of(input logic [3:0] c);
        if (c == 4'd1 || c == 4'd2) return ADD_LAT;
        if (c == 4'd5 || c == 4'd6) return SHIFT_LAT;
        return 1;
    endfunction

    function automatic logic [33:0] ref_exec(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] s;
        s = 64'(a) + 64'(b);
        case (c)
            4'd1:    return (s > 64'h0000_0000_FFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            4'd2:    return (a < b) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5:    return {2'd1, a << b[4:0]};
            4'd6:    return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // Command captured at edge e is popped once the executor is free and
    // answers LAT edges later; it is lost if FIFO_DEPTH earlier ones still wait.
    task automatic model_capture(input int e, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int pop_e;
        int r;
        logic [33:0] res;
        while (pend_pop.size() > 0 && pend_pop[0] <= e) void'(pend_pop.pop_front());
        if (c != 4'd0) begin
            if (pend_pop.size() >= FIFO_DEPTH) begin
                m_drop = 1'b1;
            end else begin
                pop_e = (e + 1 > last_r + 1) ? e + 1 : last_r + 1;
                r = pop_e + lat_of(c);
                res = ref_exec(c, a, b);
                exp_resp[r] = res[33:32];
                exp_data[r] = res[31:0];
                last_r = r;
                pend_pop.push_back(pop_e);
            end
        end
    endtask

    task automatic model_clear();
        pend_pop.delete();
        last_r = -1;
        m_drop = 1'b0;
        for (int i = edge_n + 1; i < NLOG; i++) begin
            exp_resp[i] = 2'd0;
            exp_data[i] = 32'd0;
        end
    endtask

    task automatic tick(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        hold_prio_req = c;
        hold_data1    = a;
        hold_data2    = b;
        @(posedge c_clk);
        edge_n++;
        if (edge_n >= NLOG - 64) begin
            $display("FAIL log_budget edge %0d exceeds %0d", edge_n, NLOG - 64);
            $fatal(1, "log budget exhausted");
        end
        model_capture(edge_n, c, a, b);
        exp_busy[edge_n] = (edge_n <= last_r);
        exp_drop[edge_n] = m_drop;
        #1;
        obs_resp[edge_n] = out_resp;
        obs_data[edge_n] = out_data;
        obs_busy[edge_n] = busy;
        obs_drop[edge_n] = drop_err;
        @(negedge c_clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold_prio_req = '0;
        @(posedge c_clk);
        @(posedge c_clk);
        @(negedge c_clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_resp !== 2'd0)  begin errors++; $display("FAIL reset_resp got %0d expected 0", out_resp); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (drop_err !== 1'b0)  begin errors++; $display("FAIL reset_drop got %b expected 0", drop_err); end
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  r;
        logic [31:0] d;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[11];
        int s, ecap, r;
        logic [1:0] er;
        logic [31:0] ed;
        v = '{
            '{4'd1,  32'd10,         32'd12, 2'd1, 32'd22,         ADD_LAT},
            '{4'd1,  32'hFFFF_FFFF,  32'd1,  2'd2, 32'd0,          ADD_LAT},
            '{4'd1,  32'hFFFF_FFFE,  32'd1,  2'd1, 32'hFFFF_FFFF,  ADD_LAT},
            '{4'd2,  32'd5,          32'd7,  2'd2, 32'd0,          ADD_LAT},
            '{4'd2,  32'd15,         32'd12, 2'd1, 32'd3,          ADD_LAT},
            '{4'd2,  32'd7,          32'd7,  2'd1, 32'd0,          ADD_LAT},
            '{4'd5,  32'd1,          32'd31, 2'd1, 32'h8000_0000,  SHIFT_LAT},
            '{4'd6,  32'h8000_0000,  32'd4,  2'd1, 32'h0800_0000,  SHIFT_LAT},
            '{4'd6,  32'hFFFF_FFFF,  32'h25, 2'd1, 32'h07FF_FFFF,  SHIFT_LAT},
            '{4'd3,  32'd9,          32'd9,  2'd2, 32'd0,          1},
            '{4'd15, 32'd1,          32'd2,  2'd2, 32'd0,          1}
        };
        for (int k = 0; k < 11; k++) begin
            s = edge_n;
            tick(v[k].c, v[k].a, v[k].b);
            ecap = edge_n;
            for (int j = 0; j < 8; j++) tick(4'd0, $urandom, $urandom);
            r = ecap + 1 + v[k].lat;
            for (int n = s + 1; n <= edge_n; n++) begin
                er = (n == r) ? v[k].r : 2'd0;
                ed = (n == r) ? v[k].d : 32'd0;
                checks++;
                if (obs_resp[n] !== er) begin errors++; $display("FAIL dir_resp vec %0d cyc %0d got %0d expected %0d", k, n - ecap, obs_resp[n], er); end
                checks++;
                if (obs_data[n] !== ed) begin errors++; $display("FAIL dir_data vec %0d cyc %0d got %h expected %h", k, n - ecap, obs_data[n], ed); end
            end
            checks++;
            if (obs_busy[ecap] !== 1'b1) begin errors++; $display("FAIL dir_busy_rise vec %0d got %b expected 1", k, obs_busy[ecap]); end
            checks++;
            if (obs_busy[edge_n] !== 1'b0) begin errors++; $display("FAIL dir_busy_fall vec %0d got %b expected 0", k, obs_busy[edge_n]); end
            $display("directed vec %0d cmd %0d resp %0d data %h at edge +%0d", k, v[k].c, obs_resp[r], obs_data[r], r - ecap);
        end
    endtask

    task automatic test_back_to_back();
        int s, nresp;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            s = edge_n;
            tick(4'd1, 32'd100, 32'd23);
            tick(4'd5, 32'd3,   32'd4);
            tick(4'd2, 32'd50,  32'd8);
            if (pass == 1) tick(4'd6, 32'hF0, 32'd4);
            for (int j = 0; j < 20; j++) tick(4'd0, 32'd0, 32'd0);
            nresp = 0;
            for (int n = s + 1; n <= edge_n; n++) begin
                if (obs_resp[n] != 2'd0) nresp++;
                checks++;
                if (obs_resp[n] !== exp_resp[n] || obs_data[n] !== exp_data[n]) begin
                    errors++;
                    $display("FAIL b2b_out pass %0d edge %0d got %0d/%h expected %0d/%h", pass, n, obs_resp[n], obs_data[n], exp_resp[n], exp_data[n]);
                end
                checks++;
                if (obs_busy[n] !== exp_busy[n]) begin errors++; $display("FAIL b2b_busy pass %0d edge %0d got %b expected %b", pass, n, obs_busy[n], exp_busy[n]); end
            end
            checks++;
            if (nresp != 3) begin errors++; $display("FAIL b2b_count pass %0d got %0d expected 3", pass, nresp); end
            checks++;
            if (obs_drop[edge_n] !== (pass == 1)) begin errors++; $display("FAIL b2b_drop pass %0d got %b expected %b", pass, obs_drop[edge_n], pass == 1); end
            $display("back_to_back pass %0d responses %0d drop_err %b", pass, nresp, obs_drop[edge_n]);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        tick(4'd1, 32'd100, 32'd200);
        tick(4'd1, 32'd1,   32'd2);
        tick(4'd0, 32'd0,   32'd0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (out_resp !== 2'd0)  begin errors++; $display("FAIL midrst_resp got %0d expected 0", out_resp); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL midrst_data got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
        checks++; if (drop_err !== 1'b0)  begin errors++; $display("FAIL midrst_drop got %b expected 0", drop_err); end
        @(posedge c_clk);
        @(negedge c_clk);
        reset = 1'b0;
        model_clear();
        s = edge_n;
        for (int j = 0; j < 12; j++) tick(4'd0, 32'd0, 32'd0);
        for (int n = s + 1; n <= edge_n; n++) begin
            checks++;
            if (obs_resp[n] !== 2'd0 || obs_busy[n] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after edge %0d got resp %0d busy %b expected resp 0 busy 0", n, obs_resp[n], obs_busy[n]);
            end
        end
        $display("reset_mid done: outputs quiet for %0d cycles", edge_n - s);
    endtask

    task automatic test_random();
        int s, k, nresp;
        logic [3:0] c;
        logic [31:0] a, b;
        do_reset();
        s = edge_n;
        for (int i = 0; i < 500; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                4:       c = 4'd1;
                5, 9:    c = 4'd2;
                6:       c = 4'd5;
                7:       c = 4'd6;
                8: begin
                    c = 4'($urandom_range(3, 15));
                    if (c == 4'd5 || c == 4'd6) c = 4'd4;
                end
                default: c = 4'd0;
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = 32'($urandom_range(0, 20));
                b = 32'($urandom_range(0, 20));
            end
            tick(c, a, b);
        end
        for (int j = 0; j < 20; j++) tick(4'd0, 32'd0, 32'd0);
        nresp = 0;
        for (int n = s + 1; n <= edge_n; n++) begin
            if (exp_resp[n] != 2'd0) nresp++;
            checks++;
            if (obs_resp[n] !== exp_resp[n]) begin errors++; $display("FAIL rand_resp edge %0d got %0d expected %0d", n, obs_resp[n], exp_resp[n]); end
            checks++;
            if (obs_data[n] !== exp_data[n]) begin errors++; $display("FAIL rand_data edge %0d got %h expected %h", n, obs_data[n], exp_data[n]); end
            checks++;
            if (obs_busy[n] !== exp_busy[n]) begin errors++; $display("FAIL rand_busy edge %0d got %b expected %b", n, obs_busy[n], exp_busy[n]); end
            checks++;
            if (obs_drop[n] !== exp_drop[n]) begin errors++; $display("FAIL rand_drop edge %0d got %b expected %b", n, obs_drop[n], exp_drop[n]); end
        end
        $display("random: %0d cycles, %0d expected responses, drop_err %b", edge_n - s, nresp, obs_drop[edge_n]);
    endtask

    task automatic test_idle();
        int s;
        s = edge_n;
        for (int j = 0; j < 50; j++) tick(4'd0, $urandom, $urandom);
        for (int n = s + 1; n <= edge_n; n++) begin
            checks++;
            if (obs_busy[n] !== 1'b0 || obs_resp[n] !== 2'd0) begin
                errors++;
                $display("FAIL idle edge %0d got busy %b resp %0d expected busy 0 resp 0", n, obs_busy[n], obs_resp[n]);
            end
        end
        $display("idle: %0d no-op cycles observed", edge_n - s);
    endtask

    initial begin
        for (int i = 0; i < NLOG; i++) begin
            exp_resp[i] = 2'd0;
            exp_data[i] = 32'd0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_exec_port.md
# calc_exec_port

Single-port command executor placed directly downstream of the per-port hold register in the CALC1 datapath. Consumes the registered command and two operands, queues them in a small FIFO, and executes add, subtract, shift-left and shift-right with fixed multi-cycle latencies. Returns a one-cycle response code plus result to the port output.

## Interface
- ADD_LAT, 3: cycles in EXEC for add/sub (≥1)
- SHIFT_LAT, 2: cycles in EXEC for shifts (≥1)
- FIFO_DEPTH, 2: command queue entries (≥1)

- c_clk  in  1  sole clock, rising-edge
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high
- hold_prio_req  in  [0:3]  held command: 0 no-op, 1 add, 2 sub, 5 shl, 6 shr, others invalid
- hold_data1  in  [0:31]  operand 1 (bit 0 = MSB)
- hold_data2  in  [0:31]  operand 2 / shift amount in bits [27:31]
- out_resp  out  [0:1]  0 none, 1 success, 2 overflow/underflow/invalid, 3 never driven
- out_data  out  [0:31]  result, valid only when out_resp != 0
- busy  out  1  high when state != IDLE or FIFO non-empty
- drop_err  out  1  sticky: a command was lost to FIFO overflow

## Operation
- Capture: every rising edge, hold_prio_req != 0 pushes {cmd, data1, data2} into FIFO; cmd 0 ignored.
- FSM states IDLE, EXEC, RESP.
  - IDLE: FIFO non-empty → pop, load cnt = LAT-1, go EXEC.
  - EXEC: cnt != 0 → decrement; cnt == 0 → compute, register out_resp/out_data, go RESP.
  - RESP: out_resp/out_data valid this cycle only; FIFO non-empty → pop, go EXEC; else IDLE.
- LAT per command: 1/2 → ADD_LAT; 5/6 → SHIFT_LAT; invalid → 1.
- Arithmetic:
  - add: 33-bit unsigned sum; carry out → resp 2, data 0; else resp 1, data = sum[31:0].
  - sub: data1 < data2 (unsigned) → resp 2, data 0; else resp 1, data = data1 - data2.
  - shl/shr: logical, zero fill, amount = data2[27:31] (0–31); resp 1, no overflow check.
  - invalid cmd: resp 2, data 0.
- FIFO: push and pop in same edge legal, including when full (count unchanged). Push when full without pop → command discarded, drop_err set, held until reset.
- out_resp = 0 and out_data = 0 in every cycle outside RESP.

## Timing
- Reset values: out_resp 0, out_data 0, busy 0, drop_err 0, FIFO empty, state IDLE, cnt 0.
- Reset asserted mid-operation: immediate abort, FIFO flushed, no response issued for in-flight or queued commands.
- Latency, idle empty block, command sampled at edge E: response valid for the cycle following edge E+1+LAT (add: E+4; shift: E+3; invalid: E+2).
- Throughput: one command per LAT+1 cycles; back-to-back responses separated by at least LAT cycles of out_resp = 0.
- busy rises the cycle after the capturing edge; falls the edge leaving RESP with FIFO empty.
- Responses return strictly in capture order.

## Test plan
- Reset then add 10+12 sampled at edge E → out_resp 1, out_data 22 in cycle after E+4 only; busy low after.
- Add 0xFFFFFFFF+1 → resp 2, data 0; sub 5-7 → resp 2, data 0; sub 15-12 → resp 1, data 3.
- shl 1 by data2=31 → 0x80000000 resp 1; shr 0x80000000 by 4 → 0x08000000; cmd 3 → resp 2, data 0 at E+2.
- Commands on three consecutive edges (add, shl, sub) → three responses in order, third command dropped? No: depth 2 plus pop at E+1 → all three served, drop_err 0; four on consecutive edges → drop_err 1, exactly three responses.
- Reset pulsed during EXEC of an add with one queued → no responses, outputs 0, busy 0, drop_err cleared.
- hold_prio_req 0 held 50 cycles → busy 0, out_resp 0 throughout.
